// File: rtl/latrs_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : latrs_cmd_driver
// Brief   : Sequences write/clear/preset/sample commands onto an external
//           latch (LE/LD/LRN/LSETN) and returns the sampled Q with an error flag.
// Revision: 1.0 - initial release
// ============================================================================
module latrs_cmd_driver #(
  parameter int SETUP_CYC = 2,
  parameter int WIDTH_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int REC_CYC   = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic       CMD_DATA,
  output logic       LE,
  output logic       LD,
  output logic       LRN,
  output logic       LSETN,
  input  logic       LQ,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic       RSP_Q,
  output logic       RSP_ERR
);

  // Phase counters load "length - 1" on entry and advance when they reach zero.
  localparam logic [7:0] c_SETUP_LAST = 8'(((SETUP_CYC < 1) ? 1 : SETUP_CYC) - 1);
  localparam logic [7:0] c_WIDTH_LAST = 8'(((WIDTH_CYC < 1) ? 1 : WIDTH_CYC) - 1);
  localparam logic [7:0] c_HOLD_LAST  = 8'(((HOLD_CYC  < 1) ? 1 : HOLD_CYC ) - 1);
  localparam logic [7:0] c_REC_LAST   = 8'(((REC_CYC   < 1) ? 1 : REC_CYC  ) - 1);

  localparam logic [1:0] c_OP_WRITE  = 2'b00;
  localparam logic [1:0] c_OP_CLEAR  = 2'b01;
  localparam logic [1:0] c_OP_PRESET = 2'b10;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_IDLE   = 4'd1,
    ST_SETUP  = 4'd2,
    ST_PULSE  = 4'd3,
    ST_HOLD   = 4'd4,
    ST_ASSERT = 4'd5,
    ST_RECOV  = 4'd6,
    ST_SAMPLE = 4'd7,
    ST_RESP   = 4'd8
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_op;
  logic       r_exp;
  logic       r_chk;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] w_op_nxt;
  logic       w_exp_nxt;
  logic       w_chk_nxt;
  logic       w_ld_nxt;
  logic       w_q_nxt;
  logic       w_err_nxt;
  logic       w_le_nxt;
  logic       w_lrn_nxt;
  logic       w_lsetn_nxt;
  logic       w_rdy_nxt;
  logic       w_vld_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_exp_nxt   = r_exp;
    w_chk_nxt   = r_chk;
    w_ld_nxt    = LD;
    w_q_nxt     = RSP_Q;
    w_err_nxt   = RSP_ERR;

    case (r_state)
      // LRN still low means this is the first cycle out of reset.
      ST_INIT: begin
        if (!LRN) begin
          w_cnt_nxt = c_REC_LAST;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_IDLE: begin
        if (CMD_VALID) begin
          w_op_nxt = CMD_OP;
          case (CMD_OP)
            c_OP_WRITE: begin
              w_state_nxt = ST_SETUP;
              w_cnt_nxt   = c_SETUP_LAST;
              w_ld_nxt    = CMD_DATA;
              w_exp_nxt   = CMD_DATA;
              w_chk_nxt   = 1'b1;
            end
            c_OP_CLEAR: begin
              w_state_nxt = ST_ASSERT;
              w_cnt_nxt   = c_WIDTH_LAST;
              w_exp_nxt   = 1'b0;
              w_chk_nxt   = 1'b1;
            end
            c_OP_PRESET: begin
              w_state_nxt = ST_ASSERT;
              w_cnt_nxt   = c_WIDTH_LAST;
              w_exp_nxt   = 1'b1;
              w_chk_nxt   = 1'b1;
            end
            default: begin
              w_state_nxt = ST_SAMPLE;
              w_cnt_nxt   = 8'd0;
              w_chk_nxt   = 1'b0;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = c_WIDTH_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_HOLD_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_ASSERT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RECOV;
          w_cnt_nxt   = c_REC_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_RECOV: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_SAMPLE: begin
        w_state_nxt = ST_RESP;
        w_q_nxt     = LQ;
        w_err_nxt   = r_chk & (LQ ^ r_exp);
      end
      ST_RESP: begin
        if (RSP_READY) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    // Latch controls are decoded from the next state so they leave registers.
    w_le_nxt    = (w_state_nxt == ST_PULSE);
    w_lrn_nxt   = !((w_state_nxt == ST_ASSERT) && (w_op_nxt == c_OP_CLEAR));
    w_lsetn_nxt = !((w_state_nxt == ST_ASSERT) && (w_op_nxt == c_OP_PRESET));
    w_rdy_nxt   = (w_state_nxt == ST_IDLE);
    w_vld_nxt   = (w_state_nxt == ST_RESP);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state   <= ST_INIT;
      r_cnt     <= 8'd0;
      r_op      <= 2'b00;
      r_exp     <= 1'b0;
      r_chk     <= 1'b0;
      LE        <= 1'b0;
      LD        <= 1'b0;
      LRN       <= 1'b0;
      LSETN     <= 1'b1;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_Q     <= 1'b0;
      RSP_ERR   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_exp     <= w_exp_nxt;
      r_chk     <= w_chk_nxt;
      LE        <= w_le_nxt;
      LD        <= w_ld_nxt;
      LRN       <= w_lrn_nxt;
      LSETN     <= w_lsetn_nxt;
      CMD_READY <= w_rdy_nxt;
      RSP_VALID <= w_vld_nxt;
      RSP_Q     <= w_q_nxt;
      RSP_ERR   <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latrs_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_latrs_cmd_driver
// Brief   : Directed + random bench with latch model and response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_latrs_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: default parameters; index 1: SETUP_CYC=0, WIDTH_CYC=0.
  logic       rn        [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic       cmd_data  [2];
  logic       le        [2];
  logic       ld        [2];
  logic       lrn       [2];
  logic       lsetn     [2];
  logic       lq        [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic       rsp_q     [2];
  logic       rsp_err   [2];

  logic       latch_q   [2];
  bit         force0    [2];
  bit         inited    [2];
  logic       prev_ld   [2];
  logic       prev_le   [2];
  logic       prev_rdy  [2];

  logic [1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  int   n_le, n_lrn, n_ls, lat, first;
  logic ld1;
  int   quiet;

  latrs_cmd_driver dut_a (
    .CLK(clk), .RN(rn[0]), .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]),
    .CMD_OP(cmd_op[0]), .CMD_DATA(cmd_data[0]), .LE(le[0]), .LD(ld[0]),
    .LRN(lrn[0]), .LSETN(lsetn[0]), .LQ(lq[0]), .RSP_VALID(rsp_valid[0]),
    .RSP_READY(rsp_ready[0]), .RSP_Q(rsp_q[0]), .RSP_ERR(rsp_err[0])
  );

  latrs_cmd_driver #(.SETUP_CYC(0), .WIDTH_CYC(0)) dut_b (
    .CLK(clk), .RN(rn[1]), .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]),
    .CMD_OP(cmd_op[1]), .CMD_DATA(cmd_data[1]), .LE(le[1]), .LD(ld[1]),
    .LRN(lrn[1]), .LSETN(lsetn[1]), .LQ(lq[1]), .RSP_VALID(rsp_valid[1]),
    .RSP_READY(rsp_ready[1]), .RSP_Q(rsp_q[1]), .RSP_ERR(rsp_err[1])
  );

  // Clocked latch model: reset dominates set, set dominates enable.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!lrn[u])       latch_q[u] <= 1'b0;
      else if (!lsetn[u]) latch_q[u] <= 1'b1;
      else if (le[u])    latch_q[u] <= ld[u];
    end
  end

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      lq[u] = force0[u] ? 1'b0 : latch_q[u];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Control exclusivity and LD stability, checked every cycle once out of INIT.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rn[u] && inited[u]) begin
        chk("ctrl_mutex", ($countones({le[u], ~lrn[u], ~lsetn[u]}) <= 1) ? 1 : 0, 1);
        if (ld[u] !== prev_ld[u])
          chk("ld_change_from_idle", {prev_rdy[u], prev_le[u]}, 2'b10);
      end
      if (!rn[u])             inited[u] = 1'b0;
      else if (cmd_ready[u])  inited[u] = 1'b1;
      prev_ld[u]  = ld[u];
      prev_le[u]  = le[u];
      prev_rdy[u] = cmd_ready[u];
    end
  end

  task automatic check_init(input int u);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("init_ready", cmd_ready[u], (k == 3) ? 1 : 0);
      chk("init_lrn", lrn[u], 1);
      chk("init_rsp_valid", rsp_valid[u], 0);
    end
  endtask

  task automatic do_cmd(input int u, input logic [1:0] op, input logic data, input bit frc,
                        input int bp, output int o_le, output int o_lrn, output int o_ls,
                        output int o_lat, output int o_first, output logic o_ld1);
    logic intended, eq, ee;
    logic [1:0] e;
    int wait_n;
    o_le = 0; o_lrn = 0; o_ls = 0; o_lat = 0; o_first = 0; o_ld1 = 1'b0;
    case (op)
      2'b00:   intended = data;
      2'b01:   intended = 1'b0;
      2'b10:   intended = 1'b1;
      default: intended = latch_q[u];
    endcase
    eq = frc ? 1'b0 : intended;
    ee = (op != 2'b11) && (eq != intended);
    exp_q.push_back({eq, ee});
    force0[u]   = frc;
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    cmd_data[u]  = data;
    wait_n = 0;
    while (cmd_ready[u] !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("accept_timeout", (wait_n < 20) ? 1 : 0, 1);
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    cmd_op[u]    = ~op;
    cmd_data[u]  = ~data;
    o_ld1 = ld[u];
    for (int i = 1; i <= 60; i++) begin
      if (rsp_valid[u] === 1'b1) begin
        o_lat = i;
        break;
      end
      if (le[u] === 1'b1)    o_le++;
      if (lrn[u] === 1'b0)   o_lrn++;
      if (lsetn[u] === 1'b0) o_ls++;
      if (o_first == 0 && (le[u] === 1'b1 || lrn[u] === 1'b0 || lsetn[u] === 1'b0)) o_first = i;
      @(negedge clk);
    end
    chk("rsp_timeout", (o_lat != 0) ? 1 : 0, 1);
    if (o_lat == 0) begin
      void'(exp_q.pop_front());
    end else begin
      for (int i = 0; i < bp; i++) begin
        cmd_valid[u] = 1'b1;
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid[u], 1);
        chk("bp_rsp_q", rsp_q[u], exp_q[0][1]);
        chk("bp_rsp_err", rsp_err[u], exp_q[0][0]);
        chk("bp_cmd_ready", cmd_ready[u], 0);
      end
      cmd_valid[u] = 1'b0;
      rsp_ready[u] = 1'b1;
      e = exp_q.pop_front();
      chk("rsp_q", rsp_q[u], e[1]);
      chk("rsp_err", rsp_err[u], e[0]);
      @(negedge clk);
      rsp_ready[u] = 1'b0;
      chk("rsp_valid_drop", rsp_valid[u], 0);
      chk("cmd_ready_back", cmd_ready[u], 1);
    end
    force0[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rn[u] = 1'b0; cmd_valid[u] = 1'b0; cmd_op[u] = 2'b00; cmd_data[u] = 1'b0;
      rsp_ready[u] = 1'b0; force0[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_le", le[0], 0);
    chk("rst_ld", ld[0], 0);
    chk("rst_lrn", lrn[0], 0);
    chk("rst_lsetn", lsetn[0], 1);
    chk("rst_cmd_ready", cmd_ready[0], 0);
    chk("rst_rsp_valid", rsp_valid[0], 0);
    chk("rst_rsp_q", rsp_q[0], 0);
    chk("rst_rsp_err", rsp_err[0], 0);
    chk("rst_b_lrn", lrn[1], 0);
    rn[0] = 1'b1;
    rn[1] = 1'b1;
    check_init(0);

    // Write 1 with default timing.
    do_cmd(0, 2'b00, 1'b1, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("wr1_ld_cycle1", ld1, 1);
    chk("wr1_le_first", first, 3);
    chk("wr1_le_cycles", n_le, 2);
    chk("wr1_latency", lat, 7);
    chk("wr1_no_lrn", n_lrn, 0);

    // Clear after write 1.
    do_cmd(0, 2'b01, 1'b0, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("clr_lrn_cycles", n_lrn, 2);
    chk("clr_lsetn_cycles", n_ls, 0);
    chk("clr_le_cycles", n_le, 0);
    chk("clr_first", first, 1);
    chk("clr_latency", lat, 6);

    // Preset with LQ forced low: error expected.
    do_cmd(0, 2'b10, 1'b0, 1'b1, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("pre_lsetn_cycles", n_ls, 2);
    chk("pre_lrn_cycles", n_lrn, 0);
    chk("pre_latency", lat, 6);

    // Sample reads back whatever the latch holds (preset left it at 1).
    do_cmd(0, 2'b11, 1'b0, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("smp_latency", lat, 2);
    chk("smp_no_ctrl", first, 0);
    do_cmd(0, 2'b00, 1'b0, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("wr0_ld_cycle1", ld1, 0);
    do_cmd(0, 2'b11, 1'b1, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);

    // Backpressure: five stalled cycles in RESP.
    do_cmd(0, 2'b00, 1'b1, 1'b0, 5, n_le, n_lrn, n_ls, lat, first, ld1);

    // Reset pulled during the LE pulse.
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b00; cmd_data[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 10 && le[0] !== 1'b1; i++) @(negedge clk);
    chk("abort_pulse_reached", le[0], 1);
    rn[0] = 1'b0;
    @(negedge clk);
    chk("abort_le", le[0], 0);
    chk("abort_lrn", lrn[0], 0);
    chk("abort_lsetn", lsetn[0], 1);
    chk("abort_ld", ld[0], 0);
    chk("abort_cmd_ready", cmd_ready[0], 0);
    rn[0] = 1'b1;
    check_init(0);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) quiet++;
    end
    chk("abort_no_response", quiet, 0);

    // Zero-valued SETUP/WIDTH behave as 1.
    do_cmd(1, 2'b00, 1'b1, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("b_wr_le_cycles", n_le, 1);
    chk("b_wr_le_first", first, 2);
    chk("b_wr_latency", lat, 5);
    do_cmd(1, 2'b01, 1'b0, 1'b0, 0, n_le, n_lrn, n_ls, lat, first, ld1);
    chk("b_clr_lrn_cycles", n_lrn, 1);

    for (int n = 0; n < 1000; n++) begin
      do_cmd(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
             int'($urandom_range(0, 2)), n_le, n_lrn, n_ls, lat, first, ld1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
